tx_byte_buffer: RTL

Single-clock byte FIFO with a transmit-side handshake FSM, placed between the system controller's response outputs and the UART transmitter. It absorbs back-to-back response bytes, such as the two-byte ALU multiply result or a register read, while the transmitter is busy. It then releases them one at a time using a valid/busy handshake. Overflow is flagged, never silently hidden.

---
 rtl/tx_buf_pkg.sv | 13 +
 rtl/tx_buf_ram.sv | 57 +++++
 rtl/tx_byte_buffer.sv | 100 ++++++++++
 3 files changed

// File: rtl/tx_buf_pkg.sv
// Shared types and default sizing for the transmit byte buffer.
package tx_buf_pkg;

  localparam int unsigned TX_BUF_DEPTH  = 8;
  localparam int unsigned TX_BUF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_buf_ram.sv
// Circular byte store for tx_byte_buffer: pointers, occupancy counter and
// push/pop arbitration. A push into a full store is accepted only alongside a pop.
module tx_buf_ram
  import tx_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = TX_BUF_DEPTH,
  parameter int unsigned DATA_W = TX_BUF_DATA_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tx_byte_buffer.sv
// Byte FIFO with valid/busy transmit handshake and sticky overflow flag.
// Optional macro TX_BUF_DROP_CNT_EN adds a saturating dropped-push counter DROP_CNT.
module tx_byte_buffer
  import tx_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = TX_BUF_DEPTH,
  parameter int unsigned DATA_W = TX_BUF_DATA_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     WR_VLD,
  input  logic                     TX_BUSY,
  input  logic                     OVF_CLR,
  output logic [DATA_W-1:0]        TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
`ifdef TX_BUF_DROP_CNT_EN
  output logic [7:0]               DROP_CNT,
`endif
  output logic                     OVF
);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic              load;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] rdata;

  tx_buf_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .push  (WR_VLD),
    .pop   (pop),
    .wdata (WR_DATA),
    .rdata (rdata),
    .full  (FULL),
    .empty (EMPTY),
    .level (LEVEL),
    .drop  (drop)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // TX_D_VLD decodes the state register directly so reset drops it at once.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    pop      = 1'b0;
    TX_D_VLD = 1'b0;
    case (state_q)
      IDLE: begin
        if (!EMPTY) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        TX_D_VLD = 1'b1;
        if (TX_BUSY) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      TX_P_DATA <= '0;
    else if (load) TX_P_DATA <= rdata;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         OVF <= 1'b0;
    else if (drop)    OVF <= 1'b1;
    else if (OVF_CLR) OVF <= 1'b0;
  end

`ifdef TX_BUF_DROP_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          DROP_CNT <= '0;
    else if (OVF_CLR)                  DROP_CNT <= {7'd0, drop};
    else if (drop && DROP_CNT != '1)   DROP_CNT <= DROP_CNT + 1'b1;
  end
`endif

endmodule
